alarm_timer: RTL and testbench

ALARM_TIMER -- requirements
Module: alarm_timer

---
 rtl/alarm_timer.sv | 229 ++++++++++++++++++++++
 tb/tb_alarm_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timer.sv
// alarm_timer: minutes/seconds countdown timer with stopwatch mode and alarm.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   btn_start    start / pause / resume / acknowledge (level, acts on rising edge)
//   btn_clear    return to SET with time 00:00 (level, acts on rising edge)
//   btn_inc_min  add one minute while in SET (level, acts on rising edge)
//   btn_inc_sec  add one second while in SET (level, acts on rising edge)
//   mode         0 = countdown, 1 = count-up; sampled only when leaving SET
//   dig3..dig0   BCD minute tens, minute ones, second tens, second ones
//   state_o      SET=0, RUN=1, PAUSE=2, RING=3 (also the FSM debug view)
//   done         one-cycle pulse in the first cycle state_o reads RING
//   out_speaker  square-wave tone while ringing, 0 otherwise
//
// Button handshake: there is no valid/ready pairing here. Each button is a
// level input; a request is the cycle in which the level is high and the
// previous cycle's registered level was low. Holding a button yields exactly
// one request.
module alarm_timer #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int TONE_HALF = 25_000,
  parameter int RING_SECS = 10,
  parameter int MAX_MIN   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  input  logic       mode,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [1:0] state_o,
  output logic       done,
  output logic       out_speaker
);

  localparam logic [1:0] S_SET   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_RING  = 2'd3;

  localparam int MAXC = MAX_MIN * 60;
  localparam int CW   = $clog2(MAXC);
  localparam int PW   = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int TW   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int RW   = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(MAXC - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(MAXC - 2);
  localparam logic [CW-1:0] SIXTY    = CW'(60);
  localparam logic [CW-1:0] SEC_WRAP = CW'(59);
  localparam logic [CW-1:0] MIN_WRAP = CW'((MAX_MIN - 1) * 60);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_TOP  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TONE_ONE = TW'(1);
  localparam logic [TW-1:0] TONE_TOP = TW'(TONE_HALF - 1);
  localparam logic [RW-1:0] RING_ONE = RW'(1);
  localparam logic [RW-1:0] RING_TOP = RW'(RING_SECS - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tone_q, tone_d;
  logic [RW-1:0] ring_q, ring_d;
  logic          spk_q, spk_d;
  logic          done_q, done_d;
  logic          mode_q, mode_d;
  // Order: {clear, start, inc_min, inc_sec}
  logic [3:0]    hist_q, hist_d;

  logic [3:0]    btn_now, btn_edge;
  logic          clr_e, start_e, min_e, sec_e;
  logic [6:0]    mins;
  logic [5:0]    secs;
  logic          tick;
  logic [PW-1:0] presc_next;

  assign btn_now  = {btn_clear, btn_start, btn_inc_min, btn_inc_sec};
  assign btn_edge = btn_now & ~hist_q;
  assign hist_d   = btn_now;

  // Highest-priority edge wins; the others in the same cycle are dropped.
  assign clr_e   = btn_edge[3];
  assign start_e = btn_edge[2] & ~btn_edge[3];
  assign min_e   = btn_edge[1] & ~(|btn_edge[3:2]);
  assign sec_e   = btn_edge[0] & ~(|btn_edge[3:1]);

  assign mins = 7'(count_q / SIXTY);
  assign secs = 6'(count_q % SIXTY);

  assign dig3 = 4'(mins / 7'd10);
  assign dig2 = 4'(mins % 7'd10);
  assign dig1 = 4'(secs / 6'd10);
  assign dig0 = 4'(secs % 6'd10);

  assign tick       = (presc_q == PRE_TOP);
  assign presc_next = tick ? '0 : presc_q + PRE_ONE;

  assign state_o     = state_q;
  assign done        = done_q;
  assign out_speaker = spk_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tone_d  = '0;
    ring_d  = ring_q;
    spk_d   = 1'b0;
    done_d  = 1'b0;
    mode_d  = mode_q;

    if (clr_e) begin
      state_d = S_SET;
      count_d = '0;
      presc_d = '0;
      ring_d  = '0;
    end else begin
      case (state_q)
        S_SET: begin
          if (start_e) begin
            // A zero countdown has nothing to run; the start is swallowed.
            if (mode || (count_q != '0)) begin
              state_d = S_RUN;
              presc_d = '0;
              mode_d  = mode;
            end
          end else if (min_e) begin
            count_d = (mins == 7'(MAX_MIN - 1)) ? count_q - MIN_WRAP : count_q + SIXTY;
          end else if (sec_e) begin
            count_d = (secs == 6'd59) ? count_q - SEC_WRAP : count_q + CNT_ONE;
          end
        end

        S_RUN: begin
          // The pausing cycle does not advance the prescaler, so a resume
          // picks up exactly where the count left off.
          if (start_e) begin
            state_d = S_PAUSE;
          end else begin
            presc_d = presc_next;
            if (tick) begin
              if (!mode_q) begin
                if (count_q <= CNT_ONE) begin
                  count_d = '0;
                  state_d = S_RING;
                  done_d  = 1'b1;
                  ring_d  = '0;
                end else begin
                  count_d = count_q - CNT_ONE;
                end
              end else begin
                if (count_q >= CNT_TOP) begin
                  count_d = CNT_TOP;
                  state_d = S_RING;
                  done_d  = 1'b1;
                  ring_d  = '0;
                end else begin
                  count_d = count_q + CNT_ONE;
                  if (count_q == CNT_PRE) begin
                    state_d = S_RING;
                    done_d  = 1'b1;
                    ring_d  = '0;
                  end
                end
              end
            end
          end
        end

        S_PAUSE: begin
          if (start_e) state_d = S_RUN;
        end

        default: begin  // S_RING
          if (start_e) begin
            state_d = S_SET;
          end else begin
            tone_d  = (tone_q == TONE_TOP) ? '0 : tone_q + TONE_ONE;
            spk_d   = (tone_q == TONE_TOP) ? ~spk_q : spk_q;
            presc_d = presc_next;
            if (tick) begin
              if (ring_q == RING_TOP) begin
                state_d = S_SET;
                spk_d   = 1'b0;
                tone_d  = '0;
              end else begin
                ring_d = ring_q + RING_ONE;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SET;
      count_q <= '0;
      presc_q <= '0;
      tone_q  <= '0;
      ring_q  <= '0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      // History reads as "held": a button still high as reset releases
      // must first be seen low before it can produce a request.
      hist_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tone_q  <= tone_d;
      ring_q  <= ring_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      hist_q  <= hist_d;
    end
  end

endmodule

// File: tb/tb_alarm_timer.sv
module tb_alarm_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_inc_min = 1'b0;
  logic       btn_inc_sec = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic [1:0] state_o;
  logic       done;
  logic       out_speaker;
  logic [15:0] digs;

  int n_checks = 0;
  int n_errors = 0;

  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
  localparam int B_MIN   = 2;
  localparam int B_SEC   = 3;

  assign digs = {dig3, dig2, dig1, dig0};

  alarm_timer #(
    .TICK_DIV (4),
    .TONE_HALF(2),
    .RING_SECS(2),
    .MAX_MIN  (60)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_inc_min(btn_inc_min),
    .btn_inc_sec(btn_inc_sec),
    .mode       (mode),
    .dig3       (dig3),
    .dig2       (dig2),
    .dig1       (dig1),
    .dig0       (dig0),
    .state_o    (state_o),
    .done       (done),
    .out_speaker(out_speaker)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_START: btn_start   = v;
      B_CLEAR: btn_clear   = v;
      B_MIN:   btn_inc_min = v;
      default: btn_inc_sec = v;
    endcase
  endtask

  // One request: high for the acting edge E, low again; returns at E+1.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(1);
    set_btn(b, 1'b0);
    step(1);
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_digs", 32'(digs), 32'h0000);
    check("rst_done", 32'(done), 32'd0);
    check("rst_spk", 32'(out_speaker), 32'd0);
    rst = 1'b0;
    step(1);

    // Set 02:03, countdown, first decrement 4 cycles after start edge
    press_n(B_MIN, 2);
    press_n(B_SEC, 3);
    check("set_0203", 32'(digs), 32'h0203);
    press(B_START);
    check("run_state", 32'(state_o), 32'd1);
    check("run_e1", 32'(digs), 32'h0203);
    step(2);
    check("run_e3", 32'(digs), 32'h0203);
    step(1);
    check("run_e4", 32'(digs), 32'h0202);
    press(B_CLEAR);
    check("clr_state", 32'(state_o), 32'd0);
    check("clr_digs", 32'(digs), 32'h0000);

    // 00:01 down to RING, tone, auto-return
    press(B_SEC);
    press(B_START);
    step(2);
    check("ring_pre_digs", 32'(digs), 32'h0001);
    check("ring_pre_done", 32'(done), 32'd0);
    step(1);
    check("ring_digs", 32'(digs), 32'h0000);
    check("ring_state", 32'(state_o), 32'd3);
    check("ring_done", 32'(done), 32'd1);
    check("ring_spk0", 32'(out_speaker), 32'd0);
    step(1);
    check("ring_done_off", 32'(done), 32'd0);
    check("ring_spk1", 32'(out_speaker), 32'd0);
    step(1);
    check("ring_spk2", 32'(out_speaker), 32'd1);
    step(2);
    check("ring_spk4", 32'(out_speaker), 32'd0);
    step(3);
    check("ring_last_state", 32'(state_o), 32'd3);
    check("ring_last_spk", 32'(out_speaker), 32'd1);
    step(1);
    check("ring_exit_state", 32'(state_o), 32'd0);
    check("ring_exit_spk", 32'(out_speaker), 32'd0);
    check("ring_exit_digs", 32'(digs), 32'h0000);

    // Pause at prescaler=2, resume, tick 2 cycles after resume
    press_n(B_SEC, 5);
    press(B_START);
    step(1);
    press(B_START);
    check("pause_state", 32'(state_o), 32'd2);
    step(9);
    check("pause_hold", 32'(digs), 32'h0005);
    press(B_START);
    check("resume_state", 32'(state_o), 32'd1);
    check("resume_r1", 32'(digs), 32'h0005);
    step(1);
    check("resume_r2", 32'(digs), 32'h0004);
    press(B_CLEAR);

    // Minute and second wrap, zero-countdown start ignored
    press_n(B_MIN, 59);
    press_n(B_SEC, 7);
    check("set_5907", 32'(digs), 32'h5907);
    press(B_MIN);
    check("min_wrap", 32'(digs), 32'h0007);
    press_n(B_SEC, 52);
    check("set_0059", 32'(digs), 32'h0059);
    press(B_MIN);
    press(B_SEC);
    check("sec_wrap", 32'(digs), 32'h0100);
    press(B_CLEAR);
    press(B_START);
    check("zero_start", 32'(state_o), 32'd0);

    // Count-up from 59:58 saturates into RING
    press_n(B_MIN, 59);
    press_n(B_SEC, 58);
    mode = 1'b1;
    press(B_START);
    mode = 1'b0;
    step(2);
    check("up_e3", 32'(digs), 32'h5958);
    step(1);
    check("up_e4_digs", 32'(digs), 32'h5959);
    check("up_e4_state", 32'(state_o), 32'd3);
    check("up_e4_done", 32'(done), 32'd1);
    press(B_CLEAR);

    // Clear and start coincident: clear wins
    press_n(B_SEC, 3);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    step(1);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    step(1);
    check("coinc_state", 32'(state_o), 32'd0);
    check("coinc_digs", 32'(digs), 32'h0000);

    // Reset mid-RING with start held
    press(B_SEC);
    press(B_START);
    step(5);
    check("f_ring", 32'(state_o), 32'd3);
    check("f_spk", 32'(out_speaker), 32'd1);
    mode = 1'b1;
    rst = 1'b1;
    btn_start = 1'b1;
    step(1);
    rst = 1'b0;
    check("f_rst_state", 32'(state_o), 32'd0);
    check("f_rst_spk", 32'(out_speaker), 32'd0);
    step(3);
    check("f_held_state", 32'(state_o), 32'd0);
    check("f_held_digs", 32'(digs), 32'h0000);
    btn_start = 1'b0;
    step(1);
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    check("f_restart", 32'(state_o), 32'd1);
    press(B_CLEAR);
    mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
